// File: rtl/mcb_traffic_gen_if.sv
// Purpose: bundles the write and read user-port signals of one Spartan-6 MCB port pair.
// Latency: none (wires only).
// Backpressure: carried by wr_cmd_full/wr_full (write side) and rd_cmd_full/rd_empty (read side).
// Ports (master = traffic generator, slave = MCB wrapper or memory model):
//   write command: wr_cmd_en, wr_cmd_instr, wr_cmd_bl, wr_cmd_byte_addr  <- wr_cmd_full
//   write data   : wr_en, wr_mask, wr_data                              <- wr_full, wr_underrun
//   read command : rd_cmd_en, rd_cmd_instr, rd_cmd_bl, rd_cmd_byte_addr  <- rd_cmd_full
//   read data    : rd_en                                                <- rd_data, rd_empty, rd_overflow
interface mcb_traffic_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      wr_cmd_en;
  logic [2:0]                wr_cmd_instr;
  logic [5:0]                wr_cmd_bl;
  logic [29:0]               wr_cmd_byte_addr;
  logic                      wr_cmd_full;
  logic                      wr_en;
  logic [DATA_WIDTH/8-1:0]   wr_mask;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      wr_full;
  logic                      wr_underrun;

  logic                      rd_cmd_en;
  logic [2:0]                rd_cmd_instr;
  logic [5:0]                rd_cmd_bl;
  logic [29:0]               rd_cmd_byte_addr;
  logic                      rd_cmd_full;
  logic                      rd_en;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_empty;
  logic                      rd_overflow;

  modport master (
    output wr_cmd_en, wr_cmd_instr, wr_cmd_bl, wr_cmd_byte_addr,
    input  wr_cmd_full,
    output wr_en, wr_mask, wr_data,
    input  wr_full, wr_underrun,
    output rd_cmd_en, rd_cmd_instr, rd_cmd_bl, rd_cmd_byte_addr,
    input  rd_cmd_full,
    output rd_en,
    input  rd_data, rd_empty, rd_overflow
  );

  modport slave (
    input  wr_cmd_en, wr_cmd_instr, wr_cmd_bl, wr_cmd_byte_addr,
    output wr_cmd_full,
    input  wr_en, wr_mask, wr_data,
    output wr_full, wr_underrun,
    input  rd_cmd_en, rd_cmd_instr, rd_cmd_bl, rd_cmd_byte_addr,
    output rd_cmd_full,
    input  rd_en,
    output rd_data, rd_empty, rd_overflow
  );
endinterface

// File: rtl/mcb_traffic_gen.sv
// Purpose: fills a DDR region through an MCB write port, reads it back through a read port and checks every word.
// Latency: per write burst >= BURST_LEN fill cycles + 2 command cycles; done/pass rise 1 cycle after the last read pop.
// Backpressure: wr_en = !wr_full and rd_en = !rd_empty combinationally; command issue waits while *_cmd_full is high.
// Ports:
//   clk, rst       : MCB user clock, synchronous active-high reset
//   calib_done_i   : MCB calibration complete (only looked at after reset)
//   start_i        : one-cycle run request, accepted only while waiting for start
//   busy_o/done_o  : run in progress / sticky run complete
//   pass_o         : done with no mismatches and no port fault
//   err_count_o    : saturating mismatch count; err_addr_o: byte address of first mismatch
//   mcb            : write/read user-port pair (master side)
// Build option: define MCB_TG_LFSR_EN for a 32-bit Galois LFSR data pattern instead of the word-index pattern.
// DATA_WIDTH must be 32/64/128, BURST_LEN 1..64, ADDR_BASE burst aligned, REGION_BURSTS >= 1.
module mcb_traffic_gen #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LEN     = 32,
  parameter int ADDR_BASE     = 0,
  parameter int REGION_BURSTS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               calib_done_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [15:0]        err_count_o,
  output logic [29:0]        err_addr_o,
  mcb_traffic_gen_if.master  mcb
);

  localparam logic [2:0] S_WAIT_CALIB = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_WR_FILL    = 3'd2;
  localparam logic [2:0] S_WR_CMD     = 3'd3;
  localparam logic [2:0] S_RD_CMD     = 3'd4;
  localparam logic [2:0] S_RD_DATA    = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam int          WW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int          BW         = (REGION_BURSTS > 1) ? $clog2(REGION_BURSTS) : 1;
  localparam logic [31:0] BL32       = 32'(BURST_LEN);
  localparam logic [31:0] BYTES      = 32'(DATA_WIDTH / 8);
  localparam logic [5:0]  CMD_BL     = 6'(BURST_LEN - 1);
  localparam logic [2:0]  INSTR_RD   = 3'b001;

  logic [2:0]            state_q, state_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [WW-1:0]         word_q, word_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [29:0]           err_addr_q, err_addr_d;
  logic                  wr_cmd_en_q, wr_cmd_en_d;
  logic [5:0]            wr_cmd_bl_q, wr_cmd_bl_d;
  logic [29:0]           wr_cmd_addr_q, wr_cmd_addr_d;
  logic                  rd_cmd_en_q, rd_cmd_en_d;
  logic [2:0]            rd_cmd_instr_q, rd_cmd_instr_d;
  logic [5:0]            rd_cmd_bl_q, rd_cmd_bl_d;
  logic [29:0]           rd_cmd_addr_q, rd_cmd_addr_d;

  logic                  wr_push;
  logic                  rd_pop;
  logic                  last_word;
  logic                  last_burst;
  logic [31:0]           word_idx;
  logic [29:0]           cur_addr;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  mismatch;

  assign wr_push    = (state_q == S_WR_FILL) && !mcb.wr_full;
  assign rd_pop     = (state_q == S_RD_DATA) && !mcb.rd_empty;
  assign last_word  = (word_q == WW'(BURST_LEN - 1));
  assign last_burst = (burst_q == BW'(REGION_BURSTS - 1));

  // Region-relative word index; at word 0 it is also the burst's first word,
  // so the same address serves commands and error reporting.
  assign word_idx   = 32'(burst_q) * BL32 + 32'(word_q);
  assign cur_addr   = 30'(ADDR_BASE) + 30'(word_idx * BYTES);

`ifdef MCB_TG_LFSR_EN
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1

  logic [31:0] lfsr_q, lfsr_d;

  // One LFSR serves both passes; it is reseeded when the write pass starts and
  // again when the last write command leaves, so the read pass replays it.
  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_q == S_WAIT_START && start_i) ||
        (state_q == S_WR_CMD && wr_cmd_en_q && last_burst)) begin
      lfsr_d = LFSR_SEED;
    end else if (wr_push || rd_pop) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign exp_word = {(DATA_WIDTH / 32){lfsr_q}};
`else
  assign exp_word = DATA_WIDTH'(word_idx);
`endif

  assign mismatch = rd_pop && (mcb.rd_data != exp_word);

  always_comb begin
    state_d        = state_q;
    burst_d        = burst_q;
    word_d         = word_q;
    busy_d         = busy_q;
    done_d         = done_q;
    fault_d        = fault_q | mcb.wr_underrun | mcb.rd_overflow;
    err_count_d    = err_count_q;
    err_addr_d     = err_addr_q;
    wr_cmd_en_d    = 1'b0;
    wr_cmd_bl_d    = wr_cmd_bl_q;
    wr_cmd_addr_d  = wr_cmd_addr_q;
    rd_cmd_en_d    = 1'b0;
    rd_cmd_instr_d = rd_cmd_instr_q;
    rd_cmd_bl_d    = rd_cmd_bl_q;
    rd_cmd_addr_d  = rd_cmd_addr_q;

    case (state_q)
      S_WAIT_CALIB: begin
        if (calib_done_i) state_d = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (start_i) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fault_d     = 1'b0;
          err_count_d = '0;
          err_addr_d  = '0;
          burst_d     = '0;
          word_d      = '0;
          state_d     = S_WR_FILL;
        end
      end

      S_WR_FILL: begin
        if (wr_push) begin
          if (last_word) begin
            word_d  = '0;
            state_d = S_WR_CMD;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end

      // First cycle with room raises the registered enable; the following
      // cycle (enable high) moves on, so the enable is a single-cycle pulse.
      S_WR_CMD: begin
        if (wr_cmd_en_q) begin
          if (last_burst) begin
            burst_d = '0;
            state_d = S_RD_CMD;
          end else begin
            burst_d = burst_q + BW'(1);
            state_d = S_WR_FILL;
          end
        end else if (!mcb.wr_cmd_full) begin
          wr_cmd_en_d   = 1'b1;
          wr_cmd_bl_d   = CMD_BL;
          wr_cmd_addr_d = cur_addr;
        end
      end

      S_RD_CMD: begin
        if (rd_cmd_en_q) begin
          state_d = S_RD_DATA;
        end else if (!mcb.rd_cmd_full) begin
          rd_cmd_en_d    = 1'b1;
          rd_cmd_instr_d = INSTR_RD;
          rd_cmd_bl_d    = CMD_BL;
          rd_cmd_addr_d  = cur_addr;
        end
      end

      S_RD_DATA: begin
        if (rd_pop) begin
          if (mismatch) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0)    err_addr_d  = cur_addr;
          end
          if (last_word) begin
            word_d = '0;
            if (last_burst) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              burst_d = burst_q + BW'(1);
              state_d = S_RD_CMD;
            end
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_WAIT_START;
      end

      default: begin
        state_d = S_WAIT_CALIB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_WAIT_CALIB;
      burst_q        <= '0;
      word_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
      err_count_q    <= '0;
      err_addr_q     <= '0;
      wr_cmd_en_q    <= 1'b0;
      wr_cmd_bl_q    <= '0;
      wr_cmd_addr_q  <= '0;
      rd_cmd_en_q    <= 1'b0;
      rd_cmd_instr_q <= '0;
      rd_cmd_bl_q    <= '0;
      rd_cmd_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      burst_q        <= burst_d;
      word_q         <= word_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
      err_count_q    <= err_count_d;
      err_addr_q     <= err_addr_d;
      wr_cmd_en_q    <= wr_cmd_en_d;
      wr_cmd_bl_q    <= wr_cmd_bl_d;
      wr_cmd_addr_q  <= wr_cmd_addr_d;
      rd_cmd_en_q    <= rd_cmd_en_d;
      rd_cmd_instr_q <= rd_cmd_instr_d;
      rd_cmd_bl_q    <= rd_cmd_bl_d;
      rd_cmd_addr_q  <= rd_cmd_addr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  // Combinational from registered state: an error on the final pop is already
  // in err_count_q on the cycle done_q first reads high.
  assign pass_o      = done_q && (err_count_q == 16'd0) && !fault_q;
  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;

  assign mcb.wr_cmd_en        = wr_cmd_en_q;
  assign mcb.wr_cmd_instr     = 3'b000;
  assign mcb.wr_cmd_bl        = wr_cmd_bl_q;
  assign mcb.wr_cmd_byte_addr = wr_cmd_addr_q;
  assign mcb.wr_en            = wr_push;
  assign mcb.wr_mask          = '0;
  assign mcb.wr_data          = (state_q == S_WR_FILL) ? exp_word : '0;

  assign mcb.rd_cmd_en        = rd_cmd_en_q;
  assign mcb.rd_cmd_instr     = rd_cmd_instr_q;
  assign mcb.rd_cmd_bl        = rd_cmd_bl_q;
  assign mcb.rd_cmd_byte_addr = rd_cmd_addr_q;
  assign mcb.rd_en            = rd_pop;

endmodule

// File: tb/tb_mcb_traffic_gen.sv
module tb_mcb_traffic_gen;
  localparam int DW = 32;
  localparam int BL = 32;
  localparam int NB = 4;
  localparam int NW = BL * NB;

  logic        clk;
  logic        rst;
  logic        calib;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [29:0] err_addr;

  mcb_traffic_gen_if #(.DATA_WIDTH(DW)) mcb ();

  mcb_traffic_gen #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_BASE(0), .REGION_BURSTS(NB)
  ) dut (
    .clk(clk), .rst(rst), .calib_done_i(calib), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .err_addr_o(err_addr),
    .mcb(mcb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- ideal memory model ----------------
  logic [31:0] mem [0:NW-1];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [29:0] wr_addrs[$];
  logic [29:0] rd_addrs[$];
  logic [5:0]  wr_bls[$];
  logic [5:0]  rd_bls[$];
  logic [2:0]  wr_instrs[$];
  logic [2:0]  rd_instrs[$];
  int          wr_viol = 0;
  int          rd_viol = 0;
  int          lost    = 0;
  int          corrupt_idx = -1;
  bit          wr_full_rand = 1'b0;

  logic        s_wr_en = 1'b0, s_wr_cmd_en = 1'b0, s_rd_en = 1'b0, s_rd_cmd_en = 1'b0;
  logic [31:0] s_wr_data = '0;
  logic [29:0] s_wr_addr = '0, s_rd_addr = '0;
  logic [5:0]  s_wr_bl = '0, s_rd_bl = '0;
  logic [2:0]  s_wr_instr = '0, s_rd_instr = '0;

  // Sample what the DUT presents this cycle; it commits on the next rising edge.
  always @(negedge clk) begin
    s_wr_en     = mcb.wr_en;
    s_wr_data   = mcb.wr_data;
    s_wr_cmd_en = mcb.wr_cmd_en;
    s_wr_addr   = mcb.wr_cmd_byte_addr;
    s_wr_bl     = mcb.wr_cmd_bl;
    s_wr_instr  = mcb.wr_cmd_instr;
    s_rd_en     = mcb.rd_en;
    s_rd_cmd_en = mcb.rd_cmd_en;
    s_rd_addr   = mcb.rd_cmd_byte_addr;
    s_rd_bl     = mcb.rd_cmd_bl;
    s_rd_instr  = mcb.rd_cmd_instr;
    if (mcb.wr_en === 1'b1 && mcb.wr_full === 1'b1) wr_viol++;
    if (mcb.rd_en === 1'b1 && mcb.rd_empty === 1'b1) rd_viol++;
  end

  always @(posedge clk) begin
    #1;
    if (s_wr_en) wq.push_back(s_wr_data);
    if (s_wr_cmd_en) begin
      wr_addrs.push_back(s_wr_addr);
      wr_bls.push_back(s_wr_bl);
      wr_instrs.push_back(s_wr_instr);
      for (int i = 0; i < BL; i++) begin
        int idx;
        idx = int'(s_wr_addr) / 4 + i;
        if (wq.size() == 0) lost++;
        else if (idx < NW) mem[idx] = wq.pop_front();
        else void'(wq.pop_front());
      end
    end
    if (s_rd_en && rq.size() > 0) void'(rq.pop_front());
    if (s_rd_cmd_en) begin
      rd_addrs.push_back(s_rd_addr);
      rd_bls.push_back(s_rd_bl);
      rd_instrs.push_back(s_rd_instr);
      for (int i = 0; i < BL; i++) begin
        int idx;
        logic [31:0] v;
        idx = int'(s_rd_addr) / 4 + i;
        v = (idx < NW) ? mem[idx] : 32'hDEAD_BEEF;
        if (idx == corrupt_idx) v = v ^ 32'h1;
        rq.push_back(v);
      end
    end
    mcb.rd_empty = (rq.size() == 0);
    mcb.rd_data  = (rq.size() > 0) ? rq[0] : 32'h0;
    mcb.wr_full  = wr_full_rand && ($urandom_range(0, 1) == 1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_pass"},      pass, 0);
    check({tag, "_errcnt"},    err_count, 0);
    check({tag, "_erraddr"},   err_addr, 0);
    check({tag, "_wr_en"},     mcb.wr_en, 0);
    check({tag, "_rd_en"},     mcb.rd_en, 0);
    check({tag, "_wr_cmd_en"}, mcb.wr_cmd_en, 0);
    check({tag, "_rd_cmd_en"}, mcb.rd_cmd_en, 0);
    check({tag, "_wr_data"},   mcb.wr_data, 0);
    check({tag, "_wr_fields"}, {mcb.wr_cmd_instr, mcb.wr_cmd_bl, mcb.wr_cmd_byte_addr}, 0);
    check({tag, "_rd_fields"}, {mcb.rd_cmd_instr, mcb.rd_cmd_bl, mcb.rd_cmd_byte_addr}, 0);
  endtask

  task automatic check_cmds(input string tag);
    check({tag, "_n_wr_cmds"}, wr_addrs.size(), NB);
    check({tag, "_n_rd_cmds"}, rd_addrs.size(), NB);
    if (wr_addrs.size() == NB && rd_addrs.size() == NB) begin
      for (int k = 0; k < NB; k++) begin
        check($sformatf("%s_wr_addr%0d", tag, k), wr_addrs[k], k * BL * 4);
        check($sformatf("%s_wr_bl%0d", tag, k), wr_bls[k], BL - 1);
        check($sformatf("%s_wr_instr%0d", tag, k), wr_instrs[k], 3'b000);
        check($sformatf("%s_rd_addr%0d", tag, k), rd_addrs[k], k * BL * 4);
        check($sformatf("%s_rd_bl%0d", tag, k), rd_bls[k], BL - 1);
        check($sformatf("%s_rd_instr%0d", tag, k), rd_instrs[k], 3'b001);
      end
    end
  endtask

  task automatic clear_log();
    wr_addrs.delete(); wr_bls.delete(); wr_instrs.delete();
    rd_addrs.delete(); rd_bls.delete(); rd_instrs.delete();
    wr_viol = 0; rd_viol = 0; lost = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic wait_rd_cmds(input string tag, input int cnt);
    int n;
    n = 0;
    while (rd_addrs.size() < cnt && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_rd_cmd_seen"}, rd_addrs.size() >= cnt, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst   = 1'b1;
    calib = 1'b0;
    start = 1'b0;
    mcb.wr_cmd_full = 1'b0;
    mcb.rd_cmd_full = 1'b0;
    mcb.wr_underrun = 1'b0;
    mcb.rd_overflow = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");

    // Start is ignored before calibration.
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("nocal_busy", busy, 0);
    check("nocal_cmds", wr_addrs.size() + rd_addrs.size(), 0);

    // Calibrate and run a clean pass.
    calib = 1'b1;
    pulse_start();
    check("run1_busy", busy, 1);
    wait_done("run1");
    check("run1_busy_low", busy, 0);
    check("run1_pass", pass, 1);
    check("run1_errcnt", err_count, 0);
    check("run1_erraddr", err_addr, 0);
    check_cmds("run1");
    check("run1_mem0", mem[0], 32'd0);
    check("run1_mem37", mem[37], 32'd37);
    check("run1_mem127", mem[127], 32'd127);
    check("run1_viol", wr_viol + rd_viol + lost, 0);

    // Single corrupted read word.
    check("done_sticky", done, 1);
    clear_log();
    corrupt_idx = 37;
    pulse_start();
    check("run2_done_clr", done, 0);
    check("run2_busy", busy, 1);
    wait_done("run2");
    check("run2_errcnt", err_count, 1);
    check("run2_erraddr", err_addr, 148);
    check("run2_pass", pass, 0);

    // Random write FIFO full plus a held write command FIFO.
    corrupt_idx = -1;
    clear_log();
    wr_full_rand = 1'b1;
    pulse_start();
    check("run3_errcnt_clr", err_count, 0);
    n = 0;
    while (wq.size() < BL && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("run3_fill_seen", wq.size() >= BL, 1);
    mcb.wr_cmd_full = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("run3_no_cmd_while_full", wr_addrs.size(), 0);
    mcb.wr_cmd_full = 1'b0;
    wait_done("run3");
    check("run3_pass", pass, 1);
    check("run3_wr_en_vs_full", wr_viol, 0);
    check("run3_lost", lost, 0);
    check("run3_rd_viol", rd_viol, 0);
    check_cmds("run3");
    check("run3_mem40", mem[40], 32'd40);
    check("run3_mem127", mem[127], 32'd127);
    wr_full_rand = 1'b0;

    // Reset in the middle of the read pass.
    clear_log();
    pulse_start();
    wait_rd_cmds("run4", 2);
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b1;
    calib = 1'b0;
    @(posedge clk); #1;
    check_reset("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    wq.delete();
    rq.delete();
    clear_log();
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_idle_busy", busy, 0);
    calib = 1'b1;
    pulse_start();
    check("run5_busy", busy, 1);
    wait_done("run5");
    check("run5_pass", pass, 1);
    check_cmds("run5");

    // A read overflow pulse with correct data still fails the run.
    clear_log();
    pulse_start();
    wait_rd_cmds("run6", 1);
    @(posedge clk); #1 mcb.rd_overflow = 1'b1;
    @(posedge clk); #1 mcb.rd_overflow = 1'b0;
    wait_done("run6");
    check("run6_errcnt", err_count, 0);
    check("run6_pass", pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
